// File: rtl/packet_picker.sv
// Per-slot HDMI packet selector for the data-island assembler: picks ACR, audio,
// AVI or Null at each slot boundary and buffers stereo audio pairs in an 8-deep FIFO.
module packet_picker #(
  parameter logic [19:0] AUDIO_N       = 20'd6144,
  parameter logic [19:0] AUDIO_CTS     = 20'd27000,
  parameter logic [6:0]  VIDEO_ID_CODE = 7'd1
) (
  input  logic            clk_pixel,
  input  logic            reset_n,
  input  logic            data_island_period,
  input  logic            video_field_end,
  input  logic            audio_sample_valid,
  input  logic [23:0]     audio_sample_l,
  input  logic [23:0]     audio_sample_r,
  output logic [23:0]     header,
  output logic [3:0][55:0] sub,
  output logic            audio_overflow
);

  localparam logic [7:0]  FRAME_LAST = 8'd191;
  localparam logic [23:0] ACR_HEADER = 24'h000001;
  localparam logic [23:0] AVI_HEADER = 24'h0D0282;
  localparam logic [7:0]  AVI_PB2    = 8'h08;
  localparam logic [7:0]  AVI_PB4    = {1'b0, VIDEO_ID_CODE};
  localparam logic [7:0]  AVI_SUM    = AVI_HEADER[7:0] + AVI_HEADER[15:8] + AVI_HEADER[23:16]
                                       + AVI_PB2 + AVI_PB4;
  localparam logic [7:0]  AVI_PB0    = 8'h00 - AVI_SUM;
  localparam logic [55:0] ACR_SUB    = {AUDIO_N[7:0], AUDIO_N[15:8], 4'h0, AUDIO_N[19:16],
                                        AUDIO_CTS[7:0], AUDIO_CTS[15:8], 4'h0, AUDIO_CTS[19:16],
                                        8'h00};
  localparam logic [55:0] AVI_SUB0   = {8'h00, 8'h00, AVI_PB4, 8'h00, AVI_PB2, 8'h00, AVI_PB0};

  typedef enum logic [1:0] {
    PKT_NULL  = 2'd0,
    PKT_ACR   = 2'd1,
    PKT_AUDIO = 2'd2,
    PKT_AVI   = 2'd3
  } pkt_t;

  logic [4:0]  slot_cnt;
  logic        update;
  logic        acr_pending;
  logic        avi_pending;
  logic [7:0]  frame_cnt;
  logic [7:0]  frame_next;

  logic [47:0] fifo_mem [8];
  logic [2:0]  rd_ptr;
  logic [2:0]  wr_ptr;
  logic [3:0]  fifo_cnt;
  logic [2:0]  pop_n;
  logic [2:0]  pops;
  logic [3:0]  fifo_after_pop;
  logic        write_accept;

  pkt_t        pkt_sel;
  logic [47:0] slot_entry;
  logic [3:0]  present;
  logic [3:0]  b_flags;
  logic [3:0][55:0] audio_sub;
  logic [23:0] audio_header;
  logic [23:0] next_header;
  logic [3:0][55:0] next_sub;

  // The slot counter tracks the assembler's; its last island cycle is the only reload point.
  assign update = data_island_period && (slot_cnt == 5'd31);

  always_comb begin
    pkt_sel = PKT_NULL;
    pop_n   = 3'd0;
    if (acr_pending) begin
      pkt_sel = PKT_ACR;
    end else if (fifo_cnt != 4'd0) begin
      pkt_sel = PKT_AUDIO;
      pop_n   = (fifo_cnt >= 4'd4) ? 3'd4 : fifo_cnt[2:0];
    end else if (avi_pending) begin
      pkt_sel = PKT_AVI;
    end
  end

  assign pops = update ? pop_n : 3'd0;

  // audio_sample_valid is a bare write strobe with no ready: a pair offered while
  // the FIFO has no room after this edge's pops is dropped and flagged sticky.
  assign fifo_after_pop = fifo_cnt - 4'(pops);
  assign write_accept   = audio_sample_valid && (fifo_after_pop < 4'd8);

  always_comb begin
    audio_sub  = '0;
    present    = '0;
    b_flags    = '0;
    slot_entry = '0;
    frame_next = frame_cnt;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(pop_n)) begin
        slot_entry   = fifo_mem[rd_ptr + 3'(i)];
        present[i]   = 1'b1;
        b_flags[i]   = (frame_next == 8'd0);
        audio_sub[i] = {^slot_entry[47:24], 3'b000, ^slot_entry[23:0], 3'b000, slot_entry};
        frame_next   = (frame_next == FRAME_LAST) ? 8'd0 : frame_next + 8'd1;
      end
    end
    audio_header = {b_flags, 4'b0000, 4'b0000, present, 8'h02};
  end

  always_comb begin
    next_header = '0;
    next_sub    = '0;
    case (pkt_sel)
      PKT_ACR: begin
        next_header = ACR_HEADER;
        next_sub    = {ACR_SUB, ACR_SUB, ACR_SUB, ACR_SUB};
      end
      PKT_AUDIO: begin
        next_header = audio_header;
        next_sub    = audio_sub;
      end
      PKT_AVI: begin
        next_header = AVI_HEADER;
        next_sub[0] = AVI_SUB0;
      end
      default: begin
        next_header = '0;
        next_sub    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt       <= 5'd0;
      rd_ptr         <= 3'd0;
      wr_ptr         <= 3'd0;
      fifo_cnt       <= 4'd0;
      frame_cnt      <= 8'd0;
      acr_pending    <= 1'b0;
      avi_pending    <= 1'b0;
      header         <= '0;
      sub            <= '0;
      audio_overflow <= 1'b0;
    end else begin
      if (data_island_period) begin
        slot_cnt <= slot_cnt + 5'd1;
      end
      if (update) begin
        header    <= next_header;
        sub       <= next_sub;
        rd_ptr    <= rd_ptr + pops;
        frame_cnt <= frame_next;
      end
      if (write_accept) begin
        wr_ptr <= wr_ptr + 3'd1;
      end
      fifo_cnt <= fifo_after_pop + 4'(write_accept);
      // A field-end pulse on the same edge that loads the packet keeps the flag set.
      acr_pending    <= video_field_end | (acr_pending & ~(update & (pkt_sel == PKT_ACR)));
      avi_pending    <= video_field_end | (avi_pending & ~(update & (pkt_sel == PKT_AVI)));
      audio_overflow <= audio_overflow | (audio_sample_valid & ~write_accept);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (write_accept) begin
      fifo_mem[wr_ptr] <= {audio_sample_r, audio_sample_l};
    end
  end

endmodule

// File: tb/tb_packet_picker.sv
// Self-checking bench for packet_picker: a behavioural slot/FIFO model feeds an
// expected-packet queue that is compared against header/sub on every cycle.
module tb_packet_picker;

  localparam logic [19:0] N_VAL   = 20'd6144;
  localparam logic [19:0] CTS_VAL = 20'd27000;
  localparam logic [6:0]  VIC     = 7'd1;

  logic             clk_pixel = 1'b0;
  logic             reset_n = 1'b1;
  logic             data_island_period = 1'b0;
  logic             video_field_end = 1'b0;
  logic             audio_sample_valid = 1'b0;
  logic [23:0]      audio_sample_l = '0;
  logic [23:0]      audio_sample_r = '0;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic             audio_overflow;

  packet_picker #(
    .AUDIO_N(N_VAL),
    .AUDIO_CTS(CTS_VAL),
    .VIDEO_ID_CODE(VIC)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset_n(reset_n),
    .data_island_period(data_island_period),
    .video_field_end(video_field_end),
    .audio_sample_valid(audio_sample_valid),
    .audio_sample_l(audio_sample_l),
    .audio_sample_r(audio_sample_r),
    .header(header),
    .sub(sub),
    .audio_overflow(audio_overflow)
  );

  // clock/reset
  always #5 clk_pixel = ~clk_pixel;

  // scoreboard and model state
  logic [247:0]     exp_q[$];
  logic [47:0]      m_fifo[$];
  logic [4:0]       m_cnt;
  logic             m_acr;
  logic             m_avi;
  logic             m_ovf;
  int               m_fc;
  logic [23:0]      cur_hdr;
  logic [3:0][55:0] cur_sub;
  int               vectors = 0;
  int               miscompares = 0;

  task automatic model_reset();
    exp_q.delete();
    m_fifo.delete();
    m_cnt   = 5'd0;
    m_acr   = 1'b0;
    m_avi   = 1'b0;
    m_ovf   = 1'b0;
    m_fc    = 0;
    cur_hdr = '0;
    cur_sub = '0;
  endtask

  task automatic model_packet(output logic [247:0] pkt);
    logic [23:0]      hdr;
    logic [3:0][55:0] sb;
    logic [55:0]      s;
    logic [47:0]      e;
    logic [7:0]       pb [14];
    logic [7:0]       sum;
    int               k;
    hdr = '0;
    sb  = '0;
    if (m_acr) begin
      m_acr = 1'b0;
      hdr = 24'h000001;
      s = {N_VAL[7:0], N_VAL[15:8], 4'h0, N_VAL[19:16],
           CTS_VAL[7:0], CTS_VAL[15:8], 4'h0, CTS_VAL[19:16], 8'h00};
      sb = {s, s, s, s};
    end else if (m_fifo.size() > 0) begin
      k = (m_fifo.size() > 4) ? 4 : m_fifo.size();
      hdr = 24'h000002;
      for (int i = 0; i < k; i++) begin
        e = m_fifo.pop_front();
        hdr[8 + i] = 1'b1;
        if (m_fc == 0) hdr[20 + i] = 1'b1;
        m_fc = (m_fc + 1) % 192;
        sb[i] = {^e[47:24], 3'b000, ^e[23:0], 3'b000, e};
      end
    end else if (m_avi) begin
      m_avi = 1'b0;
      hdr = 24'h0D0282;
      for (int i = 0; i < 14; i++) pb[i] = 8'h00;
      pb[2] = 8'h08;
      pb[4] = {1'b0, VIC};
      sum = 8'h82 + 8'h02 + 8'h0D;
      for (int i = 1; i < 14; i++) sum = sum + pb[i];
      pb[0] = 8'h00 - sum;
      for (int i = 0; i < 7; i++) begin
        sb[0][8*i +: 8] = pb[i];
        sb[1][8*i +: 8] = pb[7 + i];
      end
    end
    pkt = {hdr, sb};
  endtask

  // driver: one clock cycle; expected packet pushed at drive time, popped after the edge
  task automatic tick(input logic dip, input logic vfe, input logic valid,
                      input logic [23:0] l, input logic [23:0] r);
    logic         upd;
    logic [247:0] pkt;
    data_island_period = dip;
    video_field_end    = vfe;
    audio_sample_valid = valid;
    audio_sample_l     = l;
    audio_sample_r     = r;
    upd = dip && (m_cnt == 5'd31);
    if (upd) begin
      model_packet(pkt);
      exp_q.push_back(pkt);
    end
    if (valid) begin
      if (m_fifo.size() < 8) m_fifo.push_back({r, l});
      else m_ovf = 1'b1;
    end
    if (vfe) begin
      m_acr = 1'b1;
      m_avi = 1'b1;
    end
    if (dip) m_cnt = m_cnt + 5'd1;
    @(posedge clk_pixel);
    #1;
    data_island_period = 1'b0;
    video_field_end    = 1'b0;
    audio_sample_valid = 1'b0;
    if (upd) {cur_hdr, cur_sub} = exp_q.pop_front();
  endtask

  task automatic test_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (header !== 24'h0 || sub !== '0 || audio_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: hdr %h sub %h ovf %b, want all zero", header, sub, audio_overflow);
    end
    @(posedge clk_pixel);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 64; c++) begin
      tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
      vectors++;
      if (header !== 24'h0 || sub !== '0) begin
        miscompares++;
        $display("FAIL idle: cycle %0d hdr %h sub %h, want zero", c, header, sub);
      end
    end
  endtask

  task automatic test_field_end();
    tick(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 32; c++) begin
        tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
        vectors++;
        if ({header, sub} !== {cur_hdr, cur_sub}) begin
          miscompares++;
          $display("FAIL field_end: hdr %h sub %h, want hdr %h sub %h", header, sub, cur_hdr, cur_sub);
        end
      end
      vectors++;
      if (header !== ((s == 0) ? 24'h000001 : 24'h0D0282)) begin
        miscompares++;
        $display("FAIL field_end_hdr: slot %0d hdr %h", s, header);
      end
    end
  endtask

  task automatic test_audio();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b1, 24'(i), 24'h800000 + 24'(i));
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 32; c++) begin
        tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
        vectors++;
        if ({header, sub} !== {cur_hdr, cur_sub}) begin
          miscompares++;
          $display("FAIL audio: hdr %h sub %h, want hdr %h sub %h", header, sub, cur_hdr, cur_sub);
        end
      end
      vectors++;
      if (header[15:8] !== ((s == 0) ? 8'h0F : 8'h03) || header[23:16] !== ((s == 0) ? 8'h10 : 8'h00)) begin
        miscompares++;
        $display("FAIL audio_hb: slot %0d hb1 %h hb2 %h", s, header[15:8], header[23:16]);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 1'b0, 1'b1, 24'h000100 + 24'(i), 24'($urandom));
      vectors++;
      if (audio_overflow !== m_ovf) begin
        miscompares++;
        $display("FAIL overflow_flag: write %0d got %b want %b", i, audio_overflow, m_ovf);
      end
    end
    while (m_cnt != 5'd31) tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
    tick(1'b1, 1'b0, 1'b1, 24'h000109, 24'h00ABCD);
    for (int c = 0; c < 96; c++) begin
      vectors++;
      if ({header, sub} !== {cur_hdr, cur_sub} || audio_overflow !== m_ovf) begin
        miscompares++;
        $display("FAIL overflow_drain: hdr %h sub %h ovf %b, want hdr %h sub %h ovf %b",
                 header, sub, audio_overflow, cur_hdr, cur_sub, m_ovf);
      end
      tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
    end
  endtask

  task automatic test_field_end_on_update();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b1, 24'($urandom), 24'($urandom));
    while (m_cnt != 5'd31) tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
    tick(1'b1, 1'b1, 1'b0, 24'h0, 24'h0);
    for (int s = 0; s < 4; s++) begin
      vectors++;
      if (header[7:0] !== ((s == 1) ? 8'h01 : (s == 3) ? 8'h82 : 8'h02)) begin
        miscompares++;
        $display("FAIL fe_on_update_order: slot %0d hb0 %h", s, header[7:0]);
      end
      for (int c = 0; c < 32; c++) begin
        vectors++;
        if ({header, sub} !== {cur_hdr, cur_sub}) begin
          miscompares++;
          $display("FAIL fe_on_update: hdr %h sub %h, want hdr %h sub %h", header, sub, cur_hdr, cur_sub);
        end
        tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 24'($urandom), 24'($urandom));
    tick(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
    while (m_cnt != 5'd15) tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
    reset_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (header !== 24'h0 || sub !== '0 || audio_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: hdr %h sub %h ovf %b, want all zero", header, sub, audio_overflow);
    end
    @(posedge clk_pixel);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 64; c++) begin
      tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
      vectors++;
      if ({header, sub} !== {cur_hdr, cur_sub} || audio_overflow !== m_ovf) begin
        miscompares++;
        $display("FAIL reset_mid_after: hdr %h sub %h ovf %b, want hdr %h sub %h ovf %b",
                 header, sub, audio_overflow, cur_hdr, cur_sub, m_ovf);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, $urandom_range(0, 2) == 0,
           24'($urandom), 24'($urandom));
      vectors++;
      if ({header, sub} !== {cur_hdr, cur_sub} || audio_overflow !== m_ovf) begin
        miscompares++;
        $display("FAIL random: cycle %0d hdr %h sub %h ovf %b, want hdr %h sub %h ovf %b",
                 c, header, sub, audio_overflow, cur_hdr, cur_sub, m_ovf);
      end
    end
    for (int c = 0; c < 160; c++) begin
      tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
      vectors++;
      if ({header, sub} !== {cur_hdr, cur_sub}) begin
        miscompares++;
        $display("FAIL random_drain: hdr %h sub %h, want hdr %h sub %h", header, sub, cur_hdr, cur_sub);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_field_end();
    test_audio();
    test_overflow();
    test_field_end_on_update();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
